// File: rtl/accum_addr_sequencer.sv
// Accumulator write-address sequencer: walks the output rows of a tiled matmul job
// and skews each row's address across the accumulator columns, one stage per column.

module accum_col_stage #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic          en_in,
    input  logic [AW-1:0] addr_in,
    output logic          en_out,
    output logic [AW-1:0] addr_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out   <= 1'b0;
            addr_out <= '0;
        end else begin
            en_out <= en_in;
            if (ld) addr_out <= addr_in;
        end
    end

endmodule

module accum_addr_sequencer #(
    parameter  int MAX_OUT_ROWS = 128,
    parameter  int MAX_OUT_COLS = 128,
    parameter  int SYS_ARR_ROWS = 16,
    parameter  int SYS_ARR_COLS = 16,
    localparam int NSM = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int NSN = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int AW  = $clog2(MAX_OUT_ROWS * NSN),
    localparam int MW  = $clog2(NSM) + 1,
    localparam int NW  = $clog2(NSN) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MW-1:0]              num_m,
    input  logic [NW-1:0]              num_n,
    input  logic                       out_valid,
    output logic                       busy,
    output logic                       done,
    output logic [SYS_ARR_COLS*AW-1:0] col_addr,
    output logic [SYS_ARR_COLS-1:0]    col_wr_en
);

    localparam int RW = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1;
    localparam int DW = (SYS_ARR_COLS > 1) ? $clog2(SYS_ARR_COLS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [RW-1:0] sub_row;
    logic [MW-1:0] sm, lim_m, m_clamped;
    logic [NW-1:0] sn, lim_n, n_clamped;
    logic [DW-1:0] drain_cnt;

    logic          accept, row_last, sm_last, sn_last, last_row;
    logic [AW-1:0] row_addr;

    logic [SYS_ARR_COLS-1:0][AW-1:0] addr_d, addr_q;
    logic [SYS_ARR_COLS-1:0]         en_d, en_q, ld_d;

    always_comb begin
        m_clamped = num_m;
        if (num_m == '0)            m_clamped = MW'(1);
        else if (num_m > MW'(NSM))  m_clamped = MW'(NSM);
        n_clamped = num_n;
        if (num_n == '0)            n_clamped = NW'(1);
        else if (num_n > NW'(NSN))  n_clamped = NW'(NSN);
    end

    assign accept   = (state == RUN) && out_valid;
    assign row_last = (sub_row == RW'(SYS_ARR_ROWS - 1));
    assign sm_last  = (sm == lim_m - MW'(1));
    assign sn_last  = (sn == lim_n - NW'(1));
    assign last_row = row_last && sm_last && sn_last;

    // Rows leave the array bottom-first, hence the reversed row offset.
    assign row_addr = AW'(sn) * AW'(MAX_OUT_ROWS) + AW'(sm) * AW'(SYS_ARR_ROWS)
                    + AW'(SYS_ARR_ROWS - 1) - AW'(sub_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sub_row   <= '0;
            sm        <= '0;
            sn        <= '0;
            lim_m     <= '0;
            lim_n     <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lim_m   <= m_clamped;
                        lim_n   <= n_clamped;
                        sub_row <= '0;
                        sm      <= '0;
                        sn      <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (out_valid) begin
                        if (row_last) begin
                            sub_row <= '0;
                            if (sm_last) begin
                                sm <= '0;
                                sn <= sn_last ? '0 : sn + NW'(1);
                            end else begin
                                sm <= sm + MW'(1);
                            end
                        end else begin
                            sub_row <= sub_row + RW'(1);
                        end
                        if (last_row) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(SYS_ARR_COLS - 1);
                            done      <= (SYS_ARR_COLS == 1);
                        end
                    end
                end
                DRAIN: begin
                    // done lines up with the last column's final write.
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                        done      <= (drain_cnt == DW'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
        if (c == 0) begin : g_head
            assign ld_d[c]   = accept;
            assign en_d[c]   = accept;
            assign addr_d[c] = row_addr;
        end else begin : g_tail
            assign ld_d[c]   = 1'b1;
            assign en_d[c]   = en_q[c-1];
            assign addr_d[c] = addr_q[c-1];
        end

        accum_col_stage #(.AW(AW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld      (ld_d[c]),
            .en_in   (en_d[c]),
            .addr_in (addr_d[c]),
            .en_out  (en_q[c]),
            .addr_out(addr_q[c])
        );
    end

    assign col_addr  = addr_q;
    assign col_wr_en = en_q;

endmodule

// File: tb/tb_accum_addr_sequencer.sv
// Bench for accum_addr_sequencer: directed vector table, hand-written corner sequences,
// and random jobs checked every cycle against a job-level reference model.

module tb_accum_addr_sequencer;

    localparam int R = 16, C = 16, NSM = 8, NSN = 8, AW = 10, MOR = 128, H = 8192;

    logic            clk = 1'b0;
    logic            rst_n, start, out_valid;
    logic [3:0]      num_m, num_n;
    logic            busy, done;
    logic [C*AW-1:0] col_addr;
    logic [C-1:0]    col_wr_en;

    always #5 clk = ~clk;

    accum_addr_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_m    (num_m),
        .num_n    (num_n),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done),
        .col_addr (col_addr),
        .col_wr_en(col_wr_en)
    );

    int n_vec = 0, n_err = 0;

    // Reference model: the job is a queue of row addresses in acceptance order; column 0's
    // output history is kept per cycle and column c is that history c cycles later.
    int q[$];
    int phase;        // 0 idle, 1 run, 2 drain
    int drain_left;
    int cyc;
    bit h_en[H];
    int h_addr[H];
    int a0_log[$];
    int wr_cnt[C];

    function automatic int clampv(int v, int mx);
        return (v == 0) ? 1 : ((v > mx) ? mx : v);
    endfunction

    task automatic model_reset();
        q.delete();
        phase = 0; drain_left = 0; cyc = 0;
        for (int i = 0; i < H; i++) begin h_en[i] = 1'b0; h_addr[i] = 0; end
    endtask

    task automatic model_step();
        bit e0;
        int a0;
        e0 = 1'b0;
        a0 = h_addr[cyc];
        case (phase)
            0: if (start) begin
                q.delete();
                for (int sn = 0; sn < clampv(int'(num_n), NSN); sn++)
                    for (int sm = 0; sm < clampv(int'(num_m), NSM); sm++)
                        for (int r = 0; r < R; r++)
                            q.push_back(sn * MOR + sm * R + (R - 1 - r));
                phase = 1;
            end
            1: if (out_valid) begin
                a0 = q.pop_front();
                e0 = 1'b1;
                if (q.size() == 0) begin phase = 2; drain_left = C; end
            end
            default: begin
                drain_left--;
                if (drain_left == 0) phase = 0;
            end
        endcase
        cyc = (cyc + 1) % H;
        h_en[cyc]   = e0;
        h_addr[cyc] = a0;
    endtask

    task automatic check_cycle();
        logic [C-1:0]    ee;
        logic [C*AW-1:0] ea;
        bit              eb, ed;
        int              idx;
        for (int c = 0; c < C; c++) begin
            idx = (cyc - c + H) % H;
            ee[c] = h_en[idx];
            ea[c*AW +: AW] = AW'(h_addr[idx]);
        end
        eb = (phase != 0);
        ed = (phase == 2) && (drain_left == 1);
        n_vec++;
        if (busy !== eb || done !== ed || col_wr_en !== ee || col_addr !== ea) begin
            n_err++;
            $display("FAIL cycle t=%0t: busy %0b want %0b, done %0b want %0b, wr_en %h want %h, addr %h want %h",
                     $time, busy, eb, done, ed, col_wr_en, ee, col_addr, ea);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_cycle();
        for (int c = 0; c < C; c++) if (col_wr_en[c]) wr_cnt[c]++;
        if (col_wr_en[0]) a0_log.push_back(int'(col_addr[AW-1:0]));
    endtask

    // Called mid-cycle: reset must clear outputs without waiting for a clock edge.
    task automatic async_reset(input string name);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || col_wr_en !== '0 || col_addr !== '0) begin
            n_err++;
            $display("FAIL %s: busy %0b done %0b wr_en %h addr %h, all want 0",
                     name, busy, done, col_wr_en, col_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // mode: 0 start only once, 1 random extra starts, 2 start held high through done.
    task automatic run_job(input int m, input int n, input int gap_pct, input int mode,
                           output int done_at);
        int k, exp_rows, exp_last;
        bit ok;
        a0_log.delete();
        for (int c = 0; c < C; c++) wr_cnt[c] = 0;
        done_at = -1;
        num_m = 4'(m); num_n = 4'(n);
        start = 1'b1;
        out_valid = 1'($urandom_range(1));
        tick();
        k = 0;
        while (phase != 0 && k < 6000) begin
            out_valid = ($urandom_range(99) >= gap_pct);
            start = (mode == 2) ? 1'b1 : ((mode == 1) ? ($urandom_range(7) == 0) : 1'b0);
            if (mode != 0) begin
                num_m = 4'($urandom_range(15));
                num_n = 4'($urandom_range(15));
            end
            tick();
            k++;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        start = 1'b0;
        if (k >= 6000) begin
            n_vec++; n_err++;
            $display("FAIL job_timeout m=%0d n=%0d: still busy after %0d cycles", m, n, k);
        end
        exp_rows = R * clampv(m, NSM) * clampv(n, NSN);
        exp_last = (clampv(n, NSN) - 1) * MOR + (clampv(m, NSM) - 1) * R;
        ok = 1'b1;
        for (int c = 0; c < C; c++) if (wr_cnt[c] != exp_rows) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL write_count m=%0d n=%0d: col0 %0d col15 %0d, want %0d",
                     m, n, wr_cnt[0], wr_cnt[C-1], exp_rows);
        end
        n_vec++;
        if (a0_log.size() == 0 || a0_log[$] != exp_last) begin
            n_err++;
            $display("FAIL last_addr m=%0d n=%0d: got %0d want %0d", m, n,
                     (a0_log.size() == 0) ? -1 : a0_log[$], exp_last);
        end
        for (int i = 0; i < 20; i++) begin
            out_valid = 1'($urandom_range(1));
            tick();
        end
    endtask

    typedef struct {
        bit st; bit ov;
        bit busy; bit done;
        bit e0; int a0;
        bit e5; int a5;
    } vec_t;

    vec_t tbl[11];
    int   d_at;
    bit   ok;

    initial begin
        // Gap pattern 1,0,0,1 on a 1x1 job, with a stray start mid-run.
        tbl[0]  = '{1, 0, 1, 0, 0,  0, 0,  0};
        tbl[1]  = '{0, 1, 1, 0, 1, 15, 0,  0};
        tbl[2]  = '{1, 0, 1, 0, 0, 15, 0,  0};
        tbl[3]  = '{0, 0, 1, 0, 0, 15, 0,  0};
        tbl[4]  = '{0, 1, 1, 0, 1, 14, 0,  0};
        tbl[5]  = '{0, 0, 1, 0, 0, 14, 0,  0};
        tbl[6]  = '{0, 0, 1, 0, 0, 14, 1, 15};
        tbl[7]  = '{0, 0, 1, 0, 0, 14, 0, 15};
        tbl[8]  = '{0, 0, 1, 0, 0, 14, 0, 15};
        tbl[9]  = '{0, 0, 1, 0, 0, 14, 1, 14};
        tbl[10] = '{0, 0, 1, 0, 0, 14, 0, 14};

        rst_n = 1'b0; start = 1'b0; out_valid = 1'b0; num_m = 4'd1; num_n = 4'd1;
        model_reset();
        #2;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || col_wr_en !== '0 || col_addr !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy %0b done %0b wr_en %h addr %h, all want 0",
                     busy, done, col_wr_en, col_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st;
            out_valid = tbl[i].ov;
            @(posedge clk);
            #1;
            n_vec++;
            if (busy !== tbl[i].busy || done !== tbl[i].done ||
                col_wr_en[0] !== tbl[i].e0 || col_addr[AW-1:0] !== AW'(tbl[i].a0) ||
                col_wr_en[5] !== tbl[i].e5 || col_addr[5*AW +: AW] !== AW'(tbl[i].a5)) begin
                n_err++;
                $display("FAIL gap_vec[%0d]: busy %0b done %0b c0 %0b/%0d c5 %0b/%0d, want %0b %0b c0 %0b/%0d c5 %0b/%0d",
                         i, busy, done, col_wr_en[0], col_addr[AW-1:0], col_wr_en[5],
                         col_addr[5*AW +: AW], tbl[i].busy, tbl[i].done, tbl[i].e0,
                         tbl[i].a0, tbl[i].e5, tbl[i].a5);
            end
        end
        start = 1'b0;

        // Reset mid-run, then out_valid alone must not produce writes.
        async_reset("reset_mid_run");
        out_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        run_job(1, 1, 0, 0, d_at);
        ok = (a0_log.size() == 16);
        for (int i = 0; i < a0_log.size() && i < 16; i++) if (a0_log[i] != 15 - i) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL col0_seq_1x1: %0d writes, first %0d, want 16 writes 15..0",
                     a0_log.size(), (a0_log.size() > 0) ? a0_log[0] : -1);
        end
        n_vec++;
        if (d_at != 31) begin
            n_err++;
            $display("FAIL done_time_1x1: done at t0+%0d, want t0+31", d_at);
        end

        run_job(2, 2, 0, 0, d_at);
        n_vec++;
        if (a0_log.size() != 64 || a0_log[0] != 15 || a0_log[16] != 31 ||
            a0_log[32] != 143 || a0_log[48] != 159) begin
            n_err++;
            $display("FAIL submatrix_starts_2x2: size %0d, got %0d %0d %0d %0d, want 64: 15 31 143 159",
                     a0_log.size(), a0_log[0], a0_log[16], a0_log[32], a0_log[48]);
        end

        run_job(0, 15, 0, 1, d_at);
        run_job(2, 1, 30, 2, d_at);

        // Reset while draining discards the tail of the job.
        num_m = 4'd1; num_n = 4'd1; start = 1'b1; out_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        async_reset("reset_mid_drain");
        out_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(15), $urandom_range(15), $urandom_range(60), 1, d_at);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accum_addr_sequencer.md
ACCUM_ADDR_SEQUENCER -- requirements
Module: accum_addr_sequencer

Interface
REQ-001 SHALL have parameter MAX_OUT_ROWS, default 128, maximum output matrix rows.
REQ-002 SHALL have parameter MAX_OUT_COLS, default 128, maximum output matrix columns.
REQ-003 SHALL have parameter SYS_ARR_ROWS, default 16, systolic array rows.
REQ-004 SHALL have parameter SYS_ARR_COLS, default 16, systolic array columns (accumulator table columns).
REQ-005 SHALL derive NSM = MAX_OUT_ROWS/SYS_ARR_ROWS, NSN = MAX_OUT_COLS/SYS_ARR_COLS, AW = $clog2(MAX_OUT_ROWS*NSN).
REQ-006 SHALL have clk  input  1  single clock, rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have start  input  1  begin a sequence (sampled in IDLE only).
REQ-009 SHALL have num_m  input  $clog2(NSM)+1  sub-matrix row count for the job.
REQ-010 SHALL have num_n  input  $clog2(NSN)+1  sub-matrix column count for the job.
REQ-011 SHALL have out_valid  input  1  systolic array presents one output row this cycle.
REQ-012 SHALL have busy  output  1  high in RUN and DRAIN.
REQ-013 SHALL have done  output  1  one-cycle completion pulse.
REQ-014 SHALL have col_addr  output  SYS_ARR_COLS*AW  per-column write addresses concatenated, column c at bits [c*AW +: AW].
REQ-015 SHALL have col_wr_en  output  SYS_ARR_COLS  per-column write enable.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE: on start=1, SHALL latch num_m/num_n, clear counters sub_row, sm, sn to 0, go to RUN next cycle.
REQ-018 SHALL clamp latched num_m to range 1..NSM and num_n to range 1..NSN (0 -> 1, over-range -> maximum).
REQ-019 RUN: each cycle with out_valid=1, SHALL accept one row; with out_valid=0, counters hold and a bubble enters the pipeline.
REQ-020 Counter order on acceptance: sub_row increments 0..SYS_ARR_ROWS-1, wraps to 0 and increments sm; sm wraps at num_m-1 and increments sn.
REQ-021 Address of an accepted row SHALL be sn*MAX_OUT_ROWS + sm*SYS_ARR_ROWS + (SYS_ARR_ROWS-1-sub_row), computed unsigned at AW bits.
REQ-022 Stage 0 (column 0) SHALL be registered: col_addr[0]/col_wr_en[0] show the accepted row's address/valid one cycle after acceptance.
REQ-023 Column c>0 SHALL register column c-1 every cycle unconditionally, so column c writes the same address c+1 cycles after acceptance.
REQ-024 Bubbles SHALL propagate as col_wr_en=0; col_addr of a bubble stage SHALL hold its previous value.
REQ-025 Acceptance of row sub_row=SYS_ARR_ROWS-1, sm=num_m-1, sn=num_n-1 SHALL move FSM to DRAIN; out_valid is ignored thereafter.
REQ-026 DRAIN SHALL last exactly SYS_ARR_COLS cycles (down-counter); done=1 on the final DRAIN cycle, coincident with the last col_wr_en[SYS_ARR_COLS-1]=1, then IDLE.
REQ-027 start while busy SHALL be ignored; out_valid in IDLE SHALL be ignored (no wr_en).
REQ-028 start and done in the same cycle: start ignored (FSM still in DRAIN).
REQ-029 Total accepted rows per job SHALL equal SYS_ARR_ROWS*num_m*num_n (clamped values).

Reset
REQ-030 rst_n=0 at any time, including mid-RUN/DRAIN, SHALL immediately force IDLE, busy=0, done=0, all col_wr_en=0, all col_addr=0, counters and latched bounds=0; the in-flight job is discarded.
REQ-031 After rst_n deasserts, no write SHALL occur until a new start.

Verification (default parameters, AW=10)
REQ-032 Reset: assert rst_n=0 mid-RUN -> same-cycle busy=0, col_wr_en=0, col_addr=0; after release, out_valid=1 alone produces no writes.
REQ-033 num_m=1,num_n=1, out_valid held 1 from first RUN cycle t0 -> col_addr[0]=15,14,..,0 at t0+1..t0+16; column 15 shows 15..0 at t0+16..t0+31; done=1 only at t0+31; busy low at t0+32.
REQ-034 num_m=2,num_n=2, continuous -> first addresses of sub-matrices (0,0)=15, (1,0)=31, (0,1)=143, (1,1)=159; last address 144; 64 writes per column.
REQ-035 Gaps: out_valid pattern 1,0,0,1 -> column 0 wr_en 1,0,0,1 with addresses 15,-,-,14; column 5 same pattern 5 cycles later; counters unchanged during gaps.
REQ-036 Clamp/ignore: num_m=0,num_n=15 -> 16*1*8=128 writes per column, last address 896; second start during RUN produces no restart and no extra writes.
